papercomp_seq: RTL and testbench
================================

Name: papercomp_seq

Overview:
Parametrised successor to the 2-bit paper computer: a single-accumulator, multicycle sequencer with a loadable program store and a sticky overflow flag.
- Executes a small instruction set: increment, add-immediate, load-immediate, jump, jump-if-no-overflow, clear-overflow, halt and no-op.
- Uses an explicit FETCH/EXEC state machine.
- Sits under test/demo tops as the reference "toy CPU"; the program is loaded through a write port before start.

Parameters:
DATA_W, 8, accumulator and immediate width (>= PC_W)
PC_W, 4, program counter width; program store depth = 2**PC_W words

Ports:
clock  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins execution from address 0
prog_we  input  1  program store write enable
prog_addr  input  PC_W  program store write address
prog_data  input  3+DATA_W  instruction word {opcode[2:0], operand[DATA_W-1:0]}
acc  output  DATA_W  accumulator
ovf  output  1  sticky overflow flag
pc  output  PC_W  program counter
busy  output  1  high in FETCH or EXEC
halted  output  1  high in HALT

Behaviour:
- Reset (async, reset_n=0): state IDLE; acc=0, ovf=0, pc=0, ir=0, busy=0, halted=0. Program store is not reset; contents are retained across reset.
- States: IDLE, FETCH, EXEC, HALT.
- IDLE/HALT + start=1: pc<=0, acc<=0, ovf<=0, go to FETCH.
- FETCH: ir<=mem[pc] (synchronous read), go to EXEC.
- EXEC: execute ir, go to FETCH; HLT goes to HALT instead.
- Each instruction takes exactly 2 clocks; no pipelining.
- Opcodes (operand = ir[DATA_W-1:0], target = operand[PC_W-1:0]):
  - 000 NOP: pc<=pc+1.
  - 001 INC: {c,acc}<=acc+1; if c, ovf<=1; pc<=pc+1.
  - 010 ADDI: {c,acc}<=acc+operand; if c, ovf<=1; pc<=pc+1.
  - 011 LDI: acc<=operand; ovf unchanged; pc<=pc+1.
  - 100 JMP: pc<=target.
  - 101 JNO: pc<=target if ovf==0, else pc<=pc+1.
  - 110 CLO: ovf<=0; pc<=pc+1.
  - 111 HLT: pc unchanged; go to HALT.
- Arithmetic: acc is modulo 2**DATA_W. ovf is sticky and is never cleared by arithmetic. pc+1 wraps modulo 2**PC_W (last address to 0).
- prog_we: writes mem[prog_addr]<=prog_data only in IDLE or HALT; ignored while busy.
- start while busy: ignored.
- start and prog_we in the same cycle: both take effect. The write lands before the first FETCH, one cycle later, so a write to address 0 is fetched.
- reset_n low mid-run: immediate return to IDLE with all outputs at reset values; no partial instruction completes.
- No instruction-encoding errors exist: all 8 opcodes are defined.

Optional Feature:
PAPERCOMP_ICOUNT_EN
- Defined: adds output icount[15:0], the count of retired instructions, HLT included.
  - Increments on each EXEC cycle.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by an accepted start.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: pulse reset_n low asynchronously, with no clock edge during the pulse -> acc=0x00, ovf=0, pc=0, busy=0, halted=0 immediately.
- Straight-line program: load {LDI 0xFE, INC, INC, HLT}, pulse start -> halted=1 exactly 8 clocks after start is sampled; acc=0x00, ovf=1, pc=3; icount=4 if enabled.
- Loop: load {LDI 0xFD, INC, JNO 1, HLT}, start -> acc steps FE, FF, 00; ovf sets on third INC; JNO falls through; halted after 16 clocks with pc=3, acc=0x00.
- PC wrap and CLO: program of 15 NOPs then CLO at address 15, no HLT -> pc sequence 0..15 then 0 again; busy stays high; ovf=0.
- Mid-run reset: drop reset_n during EXEC of INC -> acc/ovf/pc zero at once, state IDLE; restart runs the stored program unchanged.
- Guard rails: prog_we to address 1 and start pulses while busy -> memory unchanged, execution unaffected; after HALT, prog_we writes succeed and start reruns from pc=0 with acc=0, ovf=0.

Source files
------------

// File: rtl/papercomp_seq_if.sv
// papercomp_seq_if: start pulse and program-store write port
// for the papercomp_seq toy sequencer.
interface papercomp_seq_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 4
);
  logic              start;
  logic              prog_we;
  logic [PC_W-1:0]   prog_addr;
  logic [DATA_W+2:0] prog_data;

  modport master (
    output start,
    output prog_we,
    output prog_addr,
    output prog_data
  );

  modport slave (
    input start,
    input prog_we,
    input prog_addr,
    input prog_data
  );
endinterface

// File: rtl/papercomp_seq.sv
// papercomp_seq: multicycle single-accumulator sequencer (FETCH/EXEC).
// Optional retired-instruction counter: define PAPERCOMP_ICOUNT_EN.
module papercomp_seq #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  papercomp_seq_if.slave    bus,
  output logic [DATA_W-1:0] acc,
  output logic              ovf,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
`ifdef PAPERCOMP_ICOUNT_EN
  output logic              halted,
  output logic [15:0]       icount
`else
  output logic              halted
`endif
);

  localparam int IW    = DATA_W + 3;
  localparam int DEPTH = 2 ** PC_W;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_LDI  = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_JNO  = 3'b101;
  localparam logic [2:0] OP_CLO  = 3'b110;
  localparam logic [2:0] OP_HLT  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [IW-1:0]     ir_q, ir_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;

  logic [IW-1:0]     mem [DEPTH];

  logic [2:0]        op;
  logic [DATA_W-1:0] operand;
  logic [PC_W-1:0]   target;
  logic [PC_W-1:0]   pc_inc;
  logic [DATA_W-1:0] addend;
  logic [DATA_W:0]   sum;
  logic              idle_like;
  logic              start_ok;
  logic              wr_ok;

  assign op        = ir_q[IW-1 -: 3];
  assign operand   = ir_q[DATA_W-1:0];
  assign target    = operand[PC_W-1:0];
  assign pc_inc    = pc_q + PC_W'(1);
  assign addend    = (op == OP_INC) ? DATA_W'(1) : operand;
  assign sum       = {1'b0, acc_q} + {1'b0, addend};
  assign idle_like = (state_q == S_IDLE) || (state_q == S_HALT);
  assign start_ok  = idle_like && bus.start;
  assign wr_ok     = idle_like && bus.prog_we;

  // Program store: writable only while stopped, never reset
  always_ff @(posedge clock) begin
    if (wr_ok) mem[bus.prog_addr] <= bus.prog_data;
  end

  // Next-state logic: start handling, fetch and instruction execute
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (bus.start) begin
          pc_d    = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = mem[pc_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        unique case (1'b1)
          (op == OP_NOP): ;
          (op == OP_INC), (op == OP_ADDI): begin
            acc_d = sum[DATA_W-1:0];
            if (sum[DATA_W]) ovf_d = 1'b1;
          end
          (op == OP_LDI): acc_d = operand;
          (op == OP_JMP): pc_d = target;
          (op == OP_JNO): begin
            if (!ovf_q) pc_d = target;
          end
          (op == OP_CLO): ovf_d = 1'b0;
          (op == OP_HLT): begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
    busy_d   = (state_d == S_FETCH) || (state_d == S_EXEC);
    halted_d = (state_d == S_HALT);
  end

  // Architectural state and registered status outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      pc_q     <= '0;
      ir_q     <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign acc    = acc_q;
  assign ovf    = ovf_q;
  assign pc     = pc_q;
  assign busy   = busy_q;
  assign halted = halted_q;

`ifdef PAPERCOMP_ICOUNT_EN
  logic [15:0] icount_q, icount_d;

  // Retired-instruction count, saturating, cleared by an accepted start
  always_comb begin
    icount_d = icount_q;
    if (start_ok) begin
      icount_d = '0;
    end else if (state_q == S_EXEC && icount_q != 16'hFFFF) begin
      icount_d = icount_q + 16'd1;
    end
  end

  // Counter register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) icount_q <= '0;
    else          icount_q <= icount_d;
  end

  assign icount = icount_q;
`endif

endmodule

// File: tb/tb_papercomp_seq.sv
// tb_papercomp_seq: directed, scoreboarded bench for papercomp_seq.
// Checks icount too when built with PAPERCOMP_ICOUNT_EN.
module tb_papercomp_seq;

  localparam int DW = 8;
  localparam int PW = 4;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] INC  = 3'b001;
  localparam logic [2:0] ADDI = 3'b010;
  localparam logic [2:0] LDI  = 3'b011;
  localparam logic [2:0] JMP  = 3'b100;
  localparam logic [2:0] JNO  = 3'b101;
  localparam logic [2:0] CLO  = 3'b110;
  localparam logic [2:0] HLT  = 3'b111;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [DW-1:0] acc;
  logic          ovf;
  logic [PW-1:0] pc;
  logic          busy;
  logic          halted;
`ifdef PAPERCOMP_ICOUNT_EN
  logic [15:0]   icount;
`endif

  papercomp_seq_if #(.DATA_W(DW), .PC_W(PW)) bus ();

  papercomp_seq #(.DATA_W(DW), .PC_W(PW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .acc     (acc),
    .ovf     (ovf),
    .pc      (pc),
    .busy    (busy),
`ifdef PAPERCOMP_ICOUNT_EN
    .halted  (halted),
    .icount  (icount)
`else
    .halted  (halted)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] acc;
    logic          ovf;
    logic [PW-1:0] pc;
    int            cycles;
    int            ic;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] acc_trace[$];
  logic [PW-1:0] pc_trace[$];
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [PW-1:0] a, input logic [2:0] o,
                    input logic [DW-1:0] d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = {o, d};
    tick();
    bus.prog_we   = 1'b0;
  endtask

  task automatic run(input bit guard, input bit wr0,
                     input logic [DW+2:0] w0);
    exp_t          e;
    int            cnt;
    logic [DW-1:0] last;
    bus.start = 1'b1;
    if (wr0) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = '0;
      bus.prog_data = w0;
    end
    tick();
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
    chk("start_acc", 32'(acc), 32'h0);
    chk("start_ovf", 32'(ovf), 32'h0);
    chk("start_pc", 32'(pc), 32'h0);
    chk("start_busy", 32'(busy), 32'h1);
    acc_trace.delete();
    last = acc;
    cnt  = 0;
    while (!halted && cnt < 200) begin
      if (guard && cnt == 1) begin
        bus.start     = 1'b1;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd1;
        bus.prog_data = {HLT, 8'h00};
      end
      if (guard && cnt == 2) begin
        bus.start   = 1'b0;
        bus.prog_we = 1'b0;
      end
      tick();
      cnt++;
      if (acc !== last) begin
        acc_trace.push_back(acc);
        last = acc;
      end
    end
    e = sb.pop_front();
    chk("cycles", 32'(cnt), 32'(e.cycles));
    chk("halted", 32'(halted), 32'h1);
    chk("busy_off", 32'(busy), 32'h0);
    chk("acc", 32'(acc), 32'(e.acc));
    chk("ovf", 32'(ovf), 32'(e.ovf));
    chk("pc", 32'(pc), 32'(e.pc));
`ifdef PAPERCOMP_ICOUNT_EN
    chk("icount", 32'(icount), 32'(e.ic));
`endif
  endtask

  initial begin
    logic [PW-1:0] lastpc;
    logic [DW-1:0] exp_acc[4];
    int            busy_low;

    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    #12;
    chk("rst_acc", 32'(acc), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
`ifdef PAPERCOMP_ICOUNT_EN
    chk("rst_icount", 32'(icount), 32'h0);
`endif
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick();

    // Straight line: LDI FE, INC, INC, HLT
    wr(4'd0, LDI, 8'hFE);
    wr(4'd1, INC, 8'h00);
    wr(4'd2, INC, 8'h00);
    wr(4'd3, HLT, 8'h00);
    sb.push_back('{acc: 8'h00, ovf: 1'b1, pc: 4'd3, cycles: 8, ic: 4});
    run(1'b0, 1'b0, '0);

    // Loop with JNO fall-through
    wr(4'd0, LDI, 8'hFD);
    wr(4'd2, JNO, 8'h01);
    sb.push_back('{acc: 8'h00, ovf: 1'b1, pc: 4'd3, cycles: 16, ic: 8});
    run(1'b0, 1'b0, '0);
    exp_acc = '{8'hFD, 8'hFE, 8'hFF, 8'h00};
    chk("loop_trace_len", 32'(acc_trace.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < acc_trace.size())
        chk("loop_trace", 32'(acc_trace[i]), 32'(exp_acc[i]));
    end

    // PC wrap: 15 NOPs then CLO at 15
    for (int i = 0; i < 15; i++) wr(PW'(i), NOP, 8'h00);
    wr(4'd15, CLO, 8'h00);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lastpc   = pc;
    busy_low = 0;
    pc_trace.delete();
    for (int i = 0; i < 33; i++) begin
      tick();
      if (!busy) busy_low++;
      if (pc !== lastpc) begin
        pc_trace.push_back(pc);
        lastpc = pc;
      end
    end
    chk("wrap_len", 32'(pc_trace.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < pc_trace.size())
        chk("wrap_pc", 32'(pc_trace[i]), 32'((i + 1) % 16));
    end
    chk("wrap_busy_low", 32'(busy_low), 32'd0);
    chk("wrap_ovf", 32'(ovf), 32'h0);

    // Asynchronous reset between clock edges
    reset_n = 1'b0;
    #2;
    chk("arst_acc", 32'(acc), 32'h0);
    chk("arst_pc", 32'(pc), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_halted", 32'(halted), 32'h0);
    #2 reset_n = 1'b1;
    tick();

    // Mid-run reset during EXEC of INC
    wr(4'd0, LDI, 8'h10);
    wr(4'd1, INC, 8'h00);
    wr(4'd2, INC, 8'h00);
    wr(4'd3, HLT, 8'h00);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_acc_pre", 32'(acc), 32'h10);
    chk("mid_pc_pre", 32'(pc), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_acc", 32'(acc), 32'h0);
    chk("mid_pc", 32'(pc), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    #1 reset_n = 1'b1;
    tick();
    chk("mid_idle", 32'(busy), 32'h0);
    sb.push_back('{acc: 8'h12, ovf: 1'b0, pc: 4'd3, cycles: 8, ic: 4});
    run(1'b0, 1'b0, '0);

    // Writes and start while busy are ignored
    sb.push_back('{acc: 8'h12, ovf: 1'b0, pc: 4'd3, cycles: 8, ic: 4});
    run(1'b1, 1'b0, '0);

    // After halt: writes land; start with same-cycle write to 0
    wr(4'd1, ADDI, 8'h01);
    sb.push_back('{acc: 8'h01, ovf: 1'b1, pc: 4'd3, cycles: 8, ic: 4});
    run(1'b0, 1'b1, {LDI, 8'hFF});

    // JMP over HLT, CLO, taken JNO
    wr(4'd0, LDI, 8'hF0);
    wr(4'd1, ADDI, 8'h20);
    wr(4'd2, JMP, 8'h05);
    wr(4'd5, CLO, 8'h00);
    wr(4'd6, JNO, 8'h09);
    wr(4'd9, HLT, 8'h00);
    sb.push_back('{acc: 8'h10, ovf: 1'b0, pc: 4'd9, cycles: 12, ic: 6});
    run(1'b0, 1'b0, '0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
